unidad_adelanto_riesgos: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the pipelined CPU.
- Forwarding: selects, per source operand of the instruction in Execute, whether the ALU operand comes from the register file, the Memory stage or the Writeback stage. Selection is combinational, with fixed Memory-over-Writeback priority.
- Load-use stall: a small state machine detects a load in Execute whose destination is read by the instruction in Decode. It stalls the front end and inserts bubbles for a configurable load latency.

---
 rtl/unidad_adelanto_riesgos.sv | 113 +++++++++++
 tb/tb_unidad_adelanto_riesgos.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_adelanto_riesgos.sv
// Forwarding selects and load-use stall control for the Execute stage.
// Optional stall counter built only when UNIDAD_ADELANTO_PERF_EN is defined.
module unidad_adelanto_riesgos #(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*AW-1:0]   ex_rs,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_we,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_we,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_used,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_we,
  input  logic                 ex_load,
  input  logic                 flush,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 stall,
  output logic                 bubble,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int RW = $clog2(LOAD_LAT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [2*NSRC-1:0] fwd_raw;
  logic [NSRC-1:0] id_match;
  logic            hz;
  logic            stall_c;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic mem_hit, wb_hit;
      // Memory holds the younger result, so it shadows Writeback.
      assign mem_hit = mem_we && (mem_rd == ex_rs[gi*AW +: AW]) && (mem_rd != '0);
      assign wb_hit  = wb_we  && (wb_rd  == ex_rs[gi*AW +: AW]) && (wb_rd  != '0);
      assign fwd_raw[2*gi +: 2] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
      assign id_match[gi] = id_used[gi] && (id_rs[gi*AW +: AW] == ex_rd);
    end
  endgenerate

  assign hz = ex_load && ex_we && (ex_rd != '0) && (|id_match);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = hz && !flush;
        if (hz && !flush && (LOAD_LAT > 1)) begin
          state_d = HOLD;
          rem_d   = RW'(LOAD_LAT - 1);
        end
      end
      HOLD: begin
        // Execute carries a bubble here, so hz is not re-evaluated.
        stall_c = !flush;
        if (flush || (rem_q == RW'(1))) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs are gated by rst_n so an asserted reset clears them without a clock.
  assign stall   = stall_c && rst_n;
  assign bubble  = stall_c && rst_n;
  assign fwd_sel = fwd_raw & {(2*NSRC){rst_n}};

`ifdef UNIDAD_ADELANTO_PERF_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_unidad_adelanto_riesgos.sv
// Bench for unidad_adelanto_riesgos: directed checks plus randomized traffic
// compared every cycle against a behavioural model (remaining-stall count).
module tb_unidad_adelanto_riesgos;
  localparam int AW = 5;
  localparam int NSRC = 2;
  localparam int LL = 3;
  localparam int CW = 16;
`ifdef UNIDAD_ADELANTO_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [NSRC*AW-1:0]  ex_rs;
  logic [AW-1:0]       mem_rd;
  logic                mem_we;
  logic [AW-1:0]       wb_rd;
  logic                wb_we;
  logic [NSRC*AW-1:0]  id_rs;
  logic [NSRC-1:0]     id_used;
  logic [AW-1:0]       ex_rd;
  logic                ex_we;
  logic                ex_load;
  logic                flush;
  logic [2*NSRC-1:0]   fwd_sel;
  logic                stall;
  logic                bubble;
  logic [CW-1:0]       stall_cnt;

  int passes = 0;
  int total  = 0;

  unidad_adelanto_riesgos #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .mem_rd(mem_rd), .mem_we(mem_we),
    .wb_rd(wb_rd), .wb_we(wb_we), .id_rs(id_rs), .id_used(id_used),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  int left;           // stall cycles still owed after the current one
  int unsigned mcnt;

  function automatic logic [2*NSRC-1:0] m_fwd();
    logic [2*NSRC-1:0] r;
    r = '0;
    if (rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        int rs;
        rs = int'(ex_rs[i*AW +: AW]);
        if (mem_we && int'(mem_rd) == rs && rs != 0)      r[2*i +: 2] = 2'b10;
        else if (wb_we && int'(wb_rd) == rs && rs != 0)   r[2*i +: 2] = 2'b01;
      end
    end
    return r;
  endfunction

  function automatic bit m_hz();
    bit any;
    any = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (id_used[i] && id_rs[i*AW +: AW] == ex_rd) any = 1'b1;
    return ex_load && ex_we && (ex_rd != 0) && any;
  endfunction

  function automatic bit m_stall();
    return rst_n && !flush && (left > 0 || m_hz());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left <= 0;
      mcnt <= 0;
    end else begin
      if (PERF && m_stall() && mcnt < (2**CW - 1)) mcnt <= mcnt + 1;
      if (flush)         left <= 0;
      else if (left > 0) left <= left - 1;
      else if (m_hz())   left <= LL - 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    total++;
    if (fwd_sel === m_fwd()) passes++;
    else $display("FAIL cyc_fwd_sel t=%0t got=%b exp=%b", $time, fwd_sel, m_fwd());
    total++;
    if (stall === m_stall()) passes++;
    else $display("FAIL cyc_stall t=%0t got=%b exp=%b", $time, stall, m_stall());
    total++;
    if (bubble === m_stall()) passes++;
    else $display("FAIL cyc_bubble t=%0t got=%b exp=%b", $time, bubble, m_stall());
    total++;
    if (stall_cnt === CW'(mcnt)) passes++;
    else $display("FAIL cyc_stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, mcnt);
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ex_rs = '0; mem_rd = '0; mem_we = 0; wb_rd = '0; wb_we = 0;
    id_rs = '0; id_used = '0; ex_rd = '0; ex_we = 0; ex_load = 0; flush = 0;
  endtask

  task automatic set_hazard();
    ex_load = 1; ex_we = 1; ex_rd = 5'd4; id_rs = {5'd0, 5'd4}; id_used = 2'b01;
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    ex_rs = {5'd5, 5'd3}; mem_we = 1; mem_rd = 5'd3;
    set_hazard();
    #4;
    chk("reset_fwd_sel", 32'(fwd_sel), 0);
    chk("reset_stall", 32'(stall), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);

    next_cycle();
    rst_n = 1;
    clear_in();
    ex_rs = {5'd5, 5'd3}; mem_we = 1; mem_rd = 5'd3;
    #3 chk("fwd_mem", 32'(fwd_sel), 32'b0010);

    next_cycle();
    ex_rs = {5'd7, 5'd7}; mem_we = 1; mem_rd = 5'd7; wb_we = 1; wb_rd = 5'd7;
    #3 chk("fwd_both", 32'(fwd_sel), 32'b1010);

    next_cycle();
    ex_rs = {5'd5, 5'd3}; mem_we = 1; mem_rd = 5'd3; wb_we = 1; wb_rd = 5'd5;
    #3 chk("fwd_mem_wb", 32'(fwd_sel), 32'b0110);

    next_cycle();
    ex_rs = '0; mem_we = 1; mem_rd = '0; wb_we = 1; wb_rd = '0;
    #3 chk("fwd_reg0", 32'(fwd_sel), 32'b0000);

    // Load-use, LOAD_LAT=3
    next_cycle();
    clear_in(); set_hazard();
    #3 chk("lu_c1_stall", 32'(stall), 1);
    chk("lu_c1_bubble", 32'(bubble), 1);
    next_cycle();
    ex_load = 0;
    #3 chk("lu_c2_stall", 32'(stall), 1);
    next_cycle();
    #3 chk("lu_c3_stall", 32'(stall), 1);
    next_cycle();
    #3 chk("lu_c4_stall", 32'(stall), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), PERF ? 3 : 0);

    // Flush in the second stall cycle
    next_cycle();
    set_hazard();
    #3 chk("fl_c1_stall", 32'(stall), 1);
    next_cycle();
    ex_load = 0; flush = 1;
    #3 chk("fl_c2_stall", 32'(stall), 0);
    next_cycle();
    flush = 0;
    #3 chk("fl_idle_stall", 32'(stall), 0);

    // Flush beats a simultaneous hazard
    next_cycle();
    set_hazard(); flush = 1;
    #3 chk("fl_vs_hz_stall", 32'(stall), 0);
    next_cycle();
    flush = 0; ex_load = 0;
    #3 chk("fl_vs_hz_next", 32'(stall), 0);

    // Async reset mid-HOLD
    next_cycle();
    set_hazard();
    #3 chk("rst_c1_stall", 32'(stall), 1);
    next_cycle();
    ex_load = 0;
    #1 chk("rst_hold_stall", 32'(stall), 1);
    rst_n = 0;
    #1 chk("rst_async_stall", 32'(stall), 0);
    chk("rst_async_bubble", 32'(bubble), 0);
    chk("rst_async_cnt", 32'(stall_cnt), 0);
    next_cycle();
    rst_n = 1;
    #3 chk("rst_after_stall", 32'(stall), 0);

    // Back-to-back: hazard held across the end of a stall restarts it
    next_cycle();
    set_hazard();
    next_cycle();
    next_cycle();
    next_cycle();
    #3 chk("b2b_c4_stall", 32'(stall), 1);
    ex_load = 0;
    next_cycle(); next_cycle(); next_cycle();

    // Unused operand
    next_cycle();
    set_hazard(); id_used = 2'b00;
    #3 chk("unused_stall", 32'(stall), 0);
    next_cycle();
    id_rs = {5'd4, 5'd9}; id_used = 2'b10;
    #3 chk("src1_stall", 32'(stall), 1);
    next_cycle();
    ex_load = 0;
    next_cycle(); next_cycle();

    // Randomized traffic checked by the per-cycle comparator
    for (int n = 0; n < 600; n++) begin
      next_cycle();
      for (int i = 0; i < NSRC; i++) begin
        ex_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
        id_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      mem_rd  = AW'($urandom_range(0, 7));
      wb_rd   = AW'($urandom_range(0, 7));
      ex_rd   = AW'($urandom_range(0, 7));
      mem_we  = 1'($urandom_range(0, 1));
      wb_we   = 1'($urandom_range(0, 1));
      id_used = NSRC'($urandom_range(0, 3));
      ex_we   = ($urandom_range(0, 3) != 0);
      ex_load = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 11) == 0);
    end

    next_cycle();
    clear_in();
    repeat (4) next_cycle();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
